accum_operand_entry: RTL and testbench

- Front-end stage directly upstream of the 8-bit accumulator datapath (A/S registers, carry-out to LEDR[8]).
- Turns the raw active-low pushbutton KEY[1] and slide switches SW[7:0] into a clean, debounced, single-cycle Load strobe plus a stable 8-bit Operand, all in the 50 MHz clock domain.
- Replaces the direct use of a bouncing key as a register clock; the accumulator then loads A/S on Clock while Load==1.

---
 rtl/accum_pkg.sv | 21 ++
 rtl/accum_operand_entry_sync2.sv | 28 ++
 rtl/accum_operand_entry.sv | 123 ++++++++++++
 tb/tb_accum_operand_entry.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// accum_pkg: shared types and constants for the accumulator operand-entry front end.
//   state_t             - debounce FSM states (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT)
//   DATA_W              - operand width
//   DEF_DEBOUNCE_CYCLES - 20 ms stable-level window at 50 MHz
//   DEF_REPEAT_CYCLES   - 0.5 s auto-repeat period at 50 MHz
//   DEF_CNT_W           - counter width for the default build
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DATA_W              = 8;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_CYCLES   = 25000000;
    localparam int DEF_CNT_W           = 20;

endpackage

// File: rtl/accum_operand_entry_sync2.sv
// sync2: two-flop synchroniser, width-parameterised, async active-low reset.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, flops load RST_VAL
//   d     - asynchronous input
//   q     - synchronised output
module sync2 #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/accum_operand_entry.sv
// accum_operand_entry: debounces KEY[1] into a one-cycle Load strobe and captures SW[7:0] as Operand.
//   Clock   - 50 MHz system clock
//   Resetn  - asynchronous active-low reset, released synchronously
//   KeyAddn - raw active-low add pushbutton (bouncing, asynchronous)
//   SwIn    - raw slide switches (asynchronous)
//   Operand - switch value captured on each Load, held in between
//   Load    - one-cycle strobe telling the accumulator to load
//   KeyHeld - debounced key level, 1 = pressed
// Optional feature: define ACCUM_AUTOREPEAT_EN to re-load every REPEAT_CYCLES while the key is held.
module accum_operand_entry
    import accum_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              KeyAddn,
    input  logic [DATA_W-1:0] SwIn,
    output logic [DATA_W-1:0] Operand,
    output logic              Load,
    output logic              KeyHeld
);

    // The transition edge is the one on which the counter would reach DEBOUNCE_CYCLES-1,
    // so the compare happens one count earlier; the IDLE/HELD edge that enters a wait state
    // is itself the first stable sample of the window.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
`ifdef ACCUM_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic              rst_n_s;
    logic              k_s;
    logic [DATA_W-1:0] sw_s;
    state_t            state;
    logic [CNT_W-1:0]  cnt;

    // Reset asserts asynchronously but releases on a clock edge.
    sync2 #(.W(1), .RST_VAL(1'b0)) u_rst_sync (
        .clk   (Clock),
        .rst_n (Resetn),
        .d     (1'b1),
        .q     (rst_n_s)
    );

    sync2 #(.W(1), .RST_VAL(1'b1)) u_key_sync (
        .clk   (Clock),
        .rst_n (rst_n_s),
        .d     (KeyAddn),
        .q     (k_s)
    );

    sync2 #(.W(DATA_W), .RST_VAL({DATA_W{1'b1}})) u_sw_sync (
        .clk   (Clock),
        .rst_n (rst_n_s),
        .d     (SwIn),
        .q     (sw_s)
    );

    always_ff @(posedge Clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state   <= IDLE;
            cnt     <= '0;
            Operand <= '0;
            Load    <= 1'b0;
            KeyHeld <= 1'b0;
        end else begin
            Load <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!k_s)
                        state <= PRESS_WAIT;
                end
                PRESS_WAIT: begin
                    if (k_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state   <= HELD;
                        cnt     <= '0;
                        Operand <= sw_s;
                        Load    <= 1'b1;
                        KeyHeld <= 1'b1;
                    end else
                        cnt <= cnt + 1'b1;
                end
                HELD: begin
                    if (k_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
`ifdef ACCUM_AUTOREPEAT_EN
                    else if (cnt == RP_LAST) begin
                        cnt     <= '0;
                        Operand <= sw_s;
                        Load    <= 1'b1;
                    end else
                        cnt <= cnt + 1'b1;
`endif
                end
                RELEASE_WAIT: begin
                    if (!k_s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        KeyHeld <= 1'b0;
                    end else
                        cnt <= cnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_operand_entry.sv
// tb_accum_operand_entry: randomized self-checking bench for accum_operand_entry against a run-length debounce model.
module tb_accum_operand_entry;

    localparam int D = 8;
    localparam int R = 20;
`ifdef ACCUM_AUTOREPEAT_EN
    localparam int       HOLD_LOADS = 2;
    localparam bit [7:0] HOLD_OP    = 8'hF0;
`else
    localparam int       HOLD_LOADS = 1;
    localparam bit [7:0] HOLD_OP    = 8'h0F;
`endif

    logic       clk = 1'b0;
    logic       Resetn = 1'b0;
    logic       KeyAddn = 1'b1;
    logic [7:0] SwIn = 8'h00;
    logic [7:0] Operand;
    logic       Load;
    logic       KeyHeld;

    int tests = 0;
    int fails = 0;

    // Reference model: the debounced level flips once the synchronised key has
    // disagreed with it for D consecutive samples; a press flip emits one load.
    int         m_rel = 0;
    int         run = 0;
    int         rep = 0;
    logic       p1 = 1'b1, p2 = 1'b1;
    logic [7:0] q1 = 8'hFF, q2 = 8'hFF;
    logic       m_load = 1'b0;
    logic       m_held = 1'b0;
    logic [7:0] m_op = 8'h00;

    accum_operand_entry #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (5),
        .REPEAT_CYCLES   (R)
    ) dut (
        .Clock   (clk),
        .Resetn  (Resetn),
        .KeyAddn (KeyAddn),
        .SwIn    (SwIn),
        .Operand (Operand),
        .Load    (Load),
        .KeyHeld (KeyHeld)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        logic       pressed;
        logic [7:0] sws;
        m_load = 1'b0;
        if (!Resetn) begin
            m_rel = 0; p1 = 1'b1; p2 = 1'b1; q1 = 8'hFF; q2 = 8'hFF;
            run = 0; rep = 0; m_held = 1'b0; m_op = 8'h00;
        end else if (m_rel < 2) begin
            m_rel++;
        end else begin
            pressed = !p2;
            sws = q2;
            p2 = p1; p1 = KeyAddn;
            q2 = q1; q1 = SwIn;
            if (pressed != m_held) begin
                rep = 0;
                run++;
                if (run == D) begin
                    run = 0;
                    m_held = pressed;
                    if (pressed) begin
                        m_load = 1'b1;
                        m_op = sws;
                    end
                end
            end else if (run != 0) begin
                run = 0;
                rep = 0;
            end
`ifdef ACCUM_AUTOREPEAT_EN
            else if (m_held) begin
                rep++;
                if (rep == R) begin
                    rep = 0;
                    m_load = 1'b1;
                    m_op = sws;
                end
            end
`endif
        end
    endtask

    task automatic step(input logic r, input logic k, input logic [7:0] s);
        @(negedge clk);
        Resetn = r;
        KeyAddn = k;
        SwIn = s;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 6; k++) begin
            step(k >= 3, 1'b1, 8'($urandom));
            tests++;
            if ({Load, KeyHeld, Operand} !== {m_load, m_held, m_op}) begin
                fails++;
                $display("FAIL reset_cycle k=%0d: got load=%b held=%b op=%h exp load=%b held=%b op=%h", k, Load, KeyHeld, Operand, m_load, m_held, m_op);
            end
        end
        tests++;
        if ({Load, KeyHeld, Operand} !== 10'h000) begin
            fails++;
            $display("FAIL reset_values: got load=%b held=%b op=%h exp all zero", Load, KeyHeld, Operand);
        end
    endtask

    task automatic test_bounce();
        int loads = 0;
        int held_seen = 0;
        for (int k = 0; k < 45; k++) begin
            step(1'b1, (k >= 30) ? 1'b1 : 1'(((k / 3) % 2)), 8'($urandom));
            tests++;
            if ({Load, KeyHeld, Operand} !== {m_load, m_held, m_op}) begin
                fails++;
                $display("FAIL bounce_cycle k=%0d: got load=%b held=%b op=%h exp load=%b held=%b op=%h", k, Load, KeyHeld, Operand, m_load, m_held, m_op);
            end
            if (Load) loads++;
            if (KeyHeld) held_seen++;
        end
        tests++;
        if (loads != 0 || held_seen != 0) begin
            fails++;
            $display("FAIL bounce_no_load: got loads=%0d held_cycles=%0d exp 0 and 0", loads, held_seen);
        end
        tests++;
        if (Operand !== 8'h00) begin
            fails++;
            $display("FAIL bounce_operand: got %h exp 00", Operand);
        end
    endtask

    task automatic test_clean_press();
        int loads = 0;
        int load_at = -1;
        int drop_at = -1;
        for (int k = 0; k < 45; k++) begin
            step(1'b1, k >= 30, 8'h5A);
            tests++;
            if ({Load, KeyHeld, Operand} !== {m_load, m_held, m_op}) begin
                fails++;
                $display("FAIL clean_cycle k=%0d: got load=%b held=%b op=%h exp load=%b held=%b op=%h", k, Load, KeyHeld, Operand, m_load, m_held, m_op);
            end
            if (Load) begin
                loads++;
                if (load_at < 0) load_at = k;
            end
            if (k >= 30 && !KeyHeld && drop_at < 0) drop_at = k - 30;
        end
        tests++;
        if (loads != 1) begin
            fails++;
            $display("FAIL clean_load_count: got %0d exp 1", loads);
        end
        tests++;
        if (load_at != D + 1) begin
            fails++;
            $display("FAIL clean_load_latency: got edge %0d exp edge %0d after fall", load_at + 1, D + 2);
        end
        tests++;
        if (Operand !== 8'h5A) begin
            fails++;
            $display("FAIL clean_operand: got %h exp 5a", Operand);
        end
        tests++;
        if (drop_at != D + 1) begin
            fails++;
            $display("FAIL clean_release_latency: got edge %0d exp edge %0d after rise", drop_at + 1, D + 2);
        end
    endtask

    task automatic test_switch_held();
        int loads = 0;
        for (int k = 0; k < 50; k++) begin
            step(1'b1, k >= 35, (k <= 9) ? 8'h0F : 8'hF0);
            tests++;
            if ({Load, KeyHeld, Operand} !== {m_load, m_held, m_op}) begin
                fails++;
                $display("FAIL switch_cycle k=%0d: got load=%b held=%b op=%h exp load=%b held=%b op=%h", k, Load, KeyHeld, Operand, m_load, m_held, m_op);
            end
            if (Load) loads++;
        end
        tests++;
        if (loads != HOLD_LOADS) begin
            fails++;
            $display("FAIL switch_load_count: got %0d exp %0d", loads, HOLD_LOADS);
        end
        tests++;
        if (Operand !== HOLD_OP) begin
            fails++;
            $display("FAIL switch_operand: got %h exp %h", Operand, HOLD_OP);
        end
    endtask

    task automatic test_release_bounce();
        int loads = 0;
        int drop_at = -1;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, !(k < 15 || k == 19 || k == 20), 8'($urandom));
            tests++;
            if ({Load, KeyHeld, Operand} !== {m_load, m_held, m_op}) begin
                fails++;
                $display("FAIL relbounce_cycle k=%0d: got load=%b held=%b op=%h exp load=%b held=%b op=%h", k, Load, KeyHeld, Operand, m_load, m_held, m_op);
            end
            if (Load) loads++;
            if (k >= 15 && !KeyHeld && drop_at < 0) drop_at = k;
        end
        tests++;
        if (loads != 1) begin
            fails++;
            $display("FAIL relbounce_load_count: got %0d exp 1", loads);
        end
        tests++;
        if (drop_at != 21 + D + 1) begin
            fails++;
            $display("FAIL relbounce_drop: got k=%0d exp k=%0d", drop_at, 21 + D + 1);
        end
    endtask

    task automatic test_reset_mid();
        int loads;
        for (int k = 0; k < 15; k++) begin
            step(1'b1, 1'b0, 8'h33);
            tests++;
            if ({Load, KeyHeld, Operand} !== {m_load, m_held, m_op}) begin
                fails++;
                $display("FAIL rstheld_cycle k=%0d: got load=%b held=%b op=%h exp load=%b held=%b op=%h", k, Load, KeyHeld, Operand, m_load, m_held, m_op);
            end
        end
        @(negedge clk);
        Resetn = 1'b0;
        #1;
        tests++;
        if ({Load, KeyHeld, Operand} !== 10'h000) begin
            fails++;
            $display("FAIL rstheld_async: got load=%b held=%b op=%h exp all zero", Load, KeyHeld, Operand);
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h33);
            loads = 0;
            for (int k = 0; k < 35; k++) begin
                step(1'b1, k >= 20, pass ? 8'h6C : 8'h33);
                tests++;
                if ({Load, KeyHeld, Operand} !== {m_load, m_held, m_op}) begin
                    fails++;
                    $display("FAIL rstrel_cycle p=%0d k=%0d: got load=%b held=%b op=%h exp load=%b held=%b op=%h", pass, k, Load, KeyHeld, Operand, m_load, m_held, m_op);
                end
                if (Load) loads++;
            end
            tests++;
            if (loads != 1) begin
                fails++;
                $display("FAIL rstrel_load_count p=%0d: got %0d exp 1", pass, loads);
            end
            if (pass == 0) begin
                for (int k = 0; k < 8; k++) begin
                    step(1'b1, 1'b0, 8'h33);
                    tests++;
                    if ({Load, KeyHeld, Operand} !== {m_load, m_held, m_op}) begin
                        fails++;
                        $display("FAIL rstpw_cycle k=%0d: got load=%b held=%b op=%h exp load=%b held=%b op=%h", k, Load, KeyHeld, Operand, m_load, m_held, m_op);
                    end
                end
                @(negedge clk);
                Resetn = 1'b0;
                #1;
                tests++;
                if ({Load, KeyHeld, Operand} !== 10'h000) begin
                    fails++;
                    $display("FAIL rstpw_async: got load=%b held=%b op=%h exp all zero", Load, KeyHeld, Operand);
                end
            end
        end
        tests++;
        if (Operand !== 8'h6C) begin
            fails++;
            $display("FAIL rstrel_operand: got %h exp 6c", Operand);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] acc = 8'h00;
        logic       carry = 1'b0;
        logic [7:0] ops[$];
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 30; k++) begin
                step(1'b1, k >= 15, p ? 8'h01 : 8'hFF);
                tests++;
                if ({Load, KeyHeld, Operand} !== {m_load, m_held, m_op}) begin
                    fails++;
                    $display("FAIL b2b_cycle p=%0d k=%0d: got load=%b held=%b op=%h exp load=%b held=%b op=%h", p, k, Load, KeyHeld, Operand, m_load, m_held, m_op);
                end
                if (Load) begin
                    ops.push_back(Operand);
                    {carry, acc} = {1'b0, acc} + {1'b0, Operand};
                end
            end
        end
        tests++;
        if (ops.size() != 2) begin
            fails++;
            $display("FAIL b2b_load_count: got %0d exp 2", ops.size());
        end else begin
            tests++;
            if (ops[0] !== 8'hFF || ops[1] !== 8'h01) begin
                fails++;
                $display("FAIL b2b_operands: got %h,%h exp ff,01", ops[0], ops[1]);
            end
        end
        tests++;
        if (acc !== 8'h00 || carry !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accum: got acc=%h carry=%b exp acc=00 carry=1", acc, carry);
        end
    endtask

    task automatic test_random();
        logic prev_load = 1'b0;
        logic lvl;
        int   len;
        for (int seg = 0; seg < 40; seg++) begin
            lvl = 1'($urandom);
            len = $urandom_range(1, 30);
            for (int k = 0; k < len; k++) begin
                step(1'b1, lvl, 8'($urandom));
                tests++;
                if ({Load, KeyHeld, Operand} !== {m_load, m_held, m_op}) begin
                    fails++;
                    $display("FAIL random_cycle s=%0d k=%0d: got load=%b held=%b op=%h exp load=%b held=%b op=%h", seg, k, Load, KeyHeld, Operand, m_load, m_held, m_op);
                end
                tests++;
                if (Load && prev_load) begin
                    fails++;
                    $display("FAIL random_double_load s=%0d k=%0d: got two consecutive loads exp single", seg, k);
                end
                prev_load = Load;
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clean_press();
        test_switch_held();
        test_release_bounce();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
